// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding and the default
// oversampling ratio used by the RX, TX and baud-generator blocks.
package uart_pkg;

  // Oversampling ticks per bit time produced by the shared baud generator.
  localparam int unsigned OVERSAMPLE_DEFAULT = 16;

  // Default payload width of one frame.
  localparam int unsigned DATA_BITS_DEFAULT = 8;

  // Receiver states; 3-bit encoding leaves 5..7 unused (recovered to IDLE).
  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_STOP      = 3'd3,
    RX_WAIT_HIGH = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Generic two-flop synchronizer for bringing asynchronous inputs into the
// clk domain. RESET_VALUE sets the flops' reset state so a line that idles
// high (such as a UART rx pin) does not look active while leaving reset.
module uart_sync2 #(
  parameter int unsigned           WIDTH       = 1,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two-stage capture; the first stage may go metastable, the second settles.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= RESET_VALUE;
      sync_q <= RESET_VALUE;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 1 start bit, DATA_BITS data bits LSB-first, 1 stop bit.
// The rx pin is synchronized, then sampled at the middle of each bit using
// the oversampling tick. Received bytes are offered on a valid/ready port;
// bad stop bits raise frame_err and bytes arriving while the previous one is
// still unaccepted raise overrun_err. OVERSAMPLE must be even and >= 4, and
// DATA_BITS must be at least 2.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = DATA_BITS_DEFAULT,
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 tick_os,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_busy,
  output logic                 frame_err,
  output logic                 overrun_err
);

  localparam int unsigned OS_W = $clog2(OVERSAMPLE);
  localparam int unsigned BC_W = $clog2(DATA_BITS + 1);

  // Tick counts at which the line is sampled: mid start bit is half a bit
  // after the falling edge; every later sample is a full bit after the last.
  localparam logic [OS_W-1:0] OS_HALF = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_BITS - 1);

  logic                 rxs;

  rx_state_e            state_q,     state_d;
  logic [OS_W-1:0]      os_cnt_q,    os_cnt_d;
  logic [BC_W-1:0]      bit_cnt_q,   bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q,     shift_d;
  logic [DATA_BITS-1:0] data_q,      data_d;
  logic                 valid_q,     valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q,   overrun_d;
  logic                 accept;

  // Idle-high line: reset the synchronizer to 1 so reset release is not a start bit.
  uart_sync2 #(
    .WIDTH       (1),
    .RESET_VALUE (1'b1)
  ) u_rx_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (rx),
    .q_o   (rxs)
  );

  // State, counters and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RX_IDLE;
      os_cnt_q    <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      os_cnt_q    <= os_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  // Next-state logic: bit sampling, byte hand-off and error detection.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    os_cnt_d    = os_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    // The consumer takes the held byte; a byte loaded below overrides this.
    accept = valid_q & rx_ready;
    if (accept) begin
      valid_d = 1'b0;
    end

    case (state_q)
      RX_IDLE: begin
        // Falling edge of the start bit; no tick needed to notice it.
        if (!rxs) begin
          state_d  = RX_START;
          os_cnt_d = '0;
        end
      end

      RX_START: begin
        if (tick_os) begin
          if (os_cnt_q == OS_HALF) begin
            os_cnt_d = '0;
            if (!rxs) begin
              state_d   = RX_DATA;
              bit_cnt_d = '0;
            end else begin
              // Line went back high before mid start bit: a glitch.
              state_d = RX_IDLE;
            end
          end else begin
            os_cnt_d = os_cnt_q + OS_W'(1);
          end
        end
      end

      RX_DATA: begin
        if (tick_os) begin
          if (os_cnt_q == OS_LAST) begin
            // LSB arrives first, so shifting right lands it in bit 0 at the end.
            shift_d   = {rxs, shift_q[DATA_BITS-1:1]};
            os_cnt_d  = '0;
            bit_cnt_d = bit_cnt_q + BC_W'(1);
            if (bit_cnt_q == BC_LAST) begin
              state_d = RX_STOP;
            end
          end else begin
            os_cnt_d = os_cnt_q + OS_W'(1);
          end
        end
      end

      RX_STOP: begin
        if (tick_os) begin
          if (os_cnt_q == OS_LAST) begin
            os_cnt_d = '0;
            if (rxs) begin
              // Leave at mid stop bit so a back-to-back start edge is seen.
              state_d = RX_IDLE;
              if (!valid_q || accept) begin
                data_d  = shift_q;
                valid_d = 1'b1;
              end else begin
                overrun_d = 1'b1;
              end
            end else begin
              frame_err_d = 1'b1;
              state_d     = RX_WAIT_HIGH;
            end
          end else begin
            os_cnt_d = os_cnt_q + OS_W'(1);
          end
        end
      end

      RX_WAIT_HIGH: begin
        // Hold off until the line idles so a long break reports only once.
        if (rxs) begin
          state_d = RX_IDLE;
        end
      end

      default: begin
        state_d   = RX_IDLE;
        os_cnt_d  = '0;
        bit_cnt_d = '0;
      end
    endcase
  end

  assign rx_data     = data_q;
  assign rx_valid    = valid_q;
  assign rx_busy     = (state_q != RX_IDLE);
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_q;

endmodule
